// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of sram_port_arbiter: packed per-requester request slices
// plus the shared one-hot read response.
interface sram_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AW      = 11,
    parameter int unsigned DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_lock;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Optional grant locking is compiled in with `define SRAM_ARB_LOCK_EN.
module sram_port_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned numWord     = 2048,
    parameter int unsigned numBit      = 32,
    parameter int unsigned numWordAddr = $clog2(numWord),
    parameter int unsigned LOCK_MAX    = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   scan_en_in,
    sram_port_arbiter_if.slave     bus,
    output logic                   sram_CEB,
    output logic                   sram_WEB,
    output logic [numWordAddr-1:0] sram_A,
    output logic [numBit-1:0]      sram_D,
    input  logic [numBit-1:0]      sram_Q
);
    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   ceb_q, ceb_d;
    logic                   web_q, web_d;
    logic [numWordAddr-1:0] a_q, a_d;
    logic [numBit-1:0]      d_q, d_d;
    logic [NUM_REQ-1:0]     tag_q, tag_d;
    logic [NUM_REQ-1:0]     rsp_q, rsp_d;

    logic [NUM_REQ-1:0]     gnt_c;
    logic [PW-1:0]          gnt_idx_c;
    logic [PW-1:0]          nxt_idx_c;
    logic [PW:0]            cand_c;
    logic                   found_c;
    logic                   xfer_c;
    logic                   we_sel_c;

`ifdef SRAM_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0]          cnt_q, cnt_d, cnt_nxt_c;
    logic [PW-1:0]          owner_q, owner_d;
    logic                   lock_sel_c;

    assign lock_sel_c = |(gnt_c & bus.req_lock);
`else
    logic                   unused_lock_c;

    assign unused_lock_c = ^{bus.req_lock, LOCK_MAX[0]};
`endif

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found_c   = 1'b0;
        cand_c    = '0;
        if (!scan_en_in && !RST) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                cand_c = (PW+1)'(ptr_q) + (PW+1)'(off);
                if (cand_c >= (PW+1)'(NUM_REQ)) begin
                    cand_c = cand_c - (PW+1)'(NUM_REQ);
                end
                if (!found_c && bus.req_valid[cand_c[PW-1:0]]) begin
                    found_c                   = 1'b1;
                    gnt_idx_c                 = cand_c[PW-1:0];
                    gnt_c[cand_c[PW-1:0]]     = 1'b1;
                end
            end
        end
    end

    assign xfer_c    = |gnt_c;
    assign we_sel_c  = |(gnt_c & bus.req_we);
    assign nxt_idx_c = (gnt_idx_c == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + 1'b1;

    // Next-state: SRAM command, read tag pipeline and pointer
    always_comb begin
        ceb_d = 1'b1;
        web_d = 1'b1;
        a_d   = a_q;
        d_d   = d_q;
        tag_d = '0;
        rsp_d = tag_q;
        ptr_d = ptr_q;
`ifdef SRAM_ARB_LOCK_EN
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        cnt_nxt_c = '0;
`endif
        if (xfer_c) begin
            ceb_d = 1'b0;
            web_d = ~we_sel_c;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_c[i]) begin
                    a_d = bus.req_addr[i*numWordAddr +: numWordAddr];
                    d_d = bus.req_wdata[i*numBit +: numBit];
                end
            end
            tag_d = we_sel_c ? '0 : gnt_c;
            ptr_d = nxt_idx_c;
`ifdef SRAM_ARB_LOCK_EN
            owner_d = gnt_idx_c;
            if (lock_sel_c) begin
                cnt_nxt_c = (owner_q == gnt_idx_c && cnt_q != '0) ? cnt_q + 1'b1 : CW'(1);
                if (cnt_nxt_c == CW'(LOCK_MAX)) begin
                    cnt_d = '0;
                end else begin
                    ptr_d = gnt_idx_c;
                    cnt_d = cnt_nxt_c;
                end
            end else begin
                cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
            ceb_q <= 1'b1;
            web_q <= 1'b1;
            a_q   <= '0;
            d_q   <= '0;
            tag_q <= '0;
            rsp_q <= '0;
`ifdef SRAM_ARB_LOCK_EN
            cnt_q   <= '0;
            owner_q <= '0;
`endif
        end else begin
            ptr_q <= ptr_d;
            ceb_q <= ceb_d;
            web_q <= web_d;
            a_q   <= a_d;
            d_q   <= d_d;
            tag_q <= tag_d;
            rsp_q <= rsp_d;
`ifdef SRAM_ARB_LOCK_EN
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
`endif
        end
    end

    assign bus.req_ready = gnt_c;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = sram_Q;
    assign sram_CEB      = ceb_q;
    assign sram_WEB      = web_q;
    assign sram_A        = a_q;
    assign sram_D        = d_q;
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM macro (active-low CEB/WEB, 2048x32 default) between NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Arbitration is round-robin, with one SRAM access per cycle.
- SRAM command pins are registered. Read data returns with a one-hot response strobe.
- Sits between the accelerator's load/store/DMA masters and the SRAM wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- numWord, 2048, SRAM depth.
- numBit, 32, SRAM data width.
- numWordAddr, $clog2(numWord), address width.
- LOCK_MAX, 16, max consecutive grants one requester may hold under lock (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- scan_en_in  in  1  test mode. When high, no grants are issued and sram_CEB is held at 1.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*numWordAddr  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*numBit  packed write data.
- req_lock  in  NUM_REQ  keep-grant request (optional feature).
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_rdata  out  numBit  read data, valid while any rsp_valid bit is high.
- sram_CEB  out  1  SRAM chip enable, active low, registered.
- sram_WEB  out  1  SRAM write enable, active low, registered.
- sram_A  out  numWordAddr  SRAM address, registered.
- sram_D  out  numBit  SRAM write data, registered.
- sram_Q  in  numBit  SRAM read data.

Behaviour:
- Reset (asynchronous, any time):
  - sram_CEB=1, sram_WEB=1, sram_A=0, sram_D=0.
  - rsp_valid=0, RR pointer=0, lock counter=0.
  - Any in-flight read is dropped with no response.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at the pointer, wrapping modulo NUM_REQ. The first valid requester gets req_ready.
  - req_ready is all-zero if no request is valid, if scan_en_in=1, or while RST is asserted.
- Transfer: the handshake completes when req_valid[i] & req_ready[i] at a rising CLK edge (E0). At E0:
  - sram_CEB <= 0.
  - sram_WEB <= ~req_we[i].
  - sram_A and sram_D <= slice i.
  - Pointer <= (i+1) mod NUM_REQ.
- Idle cycle: if no transfer at an edge, sram_CEB <= 1 and sram_WEB <= 1; sram_A and sram_D hold their values.
- Throughput and timing:
  - Back-to-back transfers every cycle are allowed.
  - The SRAM samples its command at E1 = E0+1.
- Read response pipeline:
  - A 1-bit-per-requester register captures the one-hot read tag at E0 and shifts it to rsp_valid at E1.
  - rsp_valid is high for exactly one cycle, after E1 and before E2.
  - rsp_rdata = sram_Q, passed through combinationally.
  - Read latency is 2 edges from acceptance.
- Writes produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data, because the SRAM commands are serialised.
- req_valid must stay asserted with stable payload until req_ready. The arbiter does not check this.
- scan_en_in rising while a read is in flight: the pending rsp_valid still fires. No new grants are issued.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- When defined:
  - If the granted requester has req_lock high, the pointer does not advance; it stays at the winner.
  - A lock counter increments on each locked grant.
  - When the counter reaches LOCK_MAX, the pointer is forced to (i+1) mod NUM_REQ and the counter clears.
  - The counter also clears on any unlocked grant or a grant to a different requester.
- When undefined: req_lock is ignored, no lock counter logic exists, and arbitration is pure round-robin.

Test Plan:
- Reset, then requester 2 reads addr 0x005 after memory was preloaded with 0xDEADBEEF → req_ready=0100 in that cycle; sram_CEB=0, sram_WEB=1, sram_A=0x005 the next cycle; rsp_valid=0100, rsp_rdata=0xDEADBEEF two edges after acceptance.
- All 4 requesters valid continuously, pointer=0 → grants 0,1,2,3,0 on consecutive cycles; sram_CEB low every cycle.
- Requester 1 writes 0x12345678 to addr 0x7FF, then requester 3 reads 0x7FF on the next cycle → rsp_valid=1000, rsp_rdata=0x12345678.
- scan_en_in=1 with all req_valid high → req_ready=0000 and sram_CEB=1 throughout; an earlier pending read still returns its rsp_valid.
- RST asserted mid-read, one cycle after acceptance → sram_CEB=1 and rsp_valid=0 immediately; no response appears after reset release.
- With SRAM_ARB_LOCK_EN, LOCK_MAX=16, requester 0 holding req_lock and requester 1 valid → requester 0 gets 16 grants, then requester 1 is granted.
